lbp_host_mem: RTL and testbench
===============================

Name: lbp_host_mem

Overview:
- Responder at the far end of the LBP engine's gray-read and lbp-write interfaces.
- Holds the W×H 8-bit gray image and serves `gray_data` for `gray_addr` requests.
- Captures every `lbp_valid` write into a result memory and flags protocol errors.
- After `finish`, exposes the result image through a registered readback port. Serves as the synthesizable host model and as the system-level memory wrapper.

Parameters:
- W, 128, image width in pixels (power of 2).
- H, 128, image height in pixels (power of 2).
- AW, 14, address width; W*H must equal 2**AW.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  gray pixel present on load_data (raster order).
- load_data  in  8  gray pixel value.
- gray_ready  out  1  image loaded; engine may start.
- gray_req  in  1  engine read request.
- gray_addr  in  AW  read address, {row,col}.
- gray_data  out  8  pixel at gray_addr.
- lbp_valid  in  1  engine write strobe.
- lbp_addr  in  AW  write address, {row,col}.
- lbp_data  in  8  LBP code.
- finish  in  1  engine done.
- restart  in  1  one-cycle pulse: rerun on same image.
- done  out  1  finish seen; readback allowed.
- wr_count  out  AW+1  number of lbp writes captured.
- dup_err  out  1  sticky: an address was written twice.
- proto_err  out  1  sticky: traffic outside READY state.
- rd_addr  in  AW  readback address.
- rd_data  out  8  result at rd_addr, registered.

Behaviour:
- Reset (reset=0, async) values:
  - outputs: gray_ready=0, done=0, wr_count=0, dup_err=0, proto_err=0, rd_data=0;
  - internals: state=LOAD, load counter=0, written-bitmap cleared.
  - Memory contents are not reset. Reset mid-operation aborts everything and returns to LOAD.
- States:
  - LOAD: each cycle with load_valid=1 writes load_data to gray_mem[ld_cnt] and increments ld_cnt. When the write at ld_cnt = W*H-1 occurs, go to READY next cycle.
  - READY: gray_ready=1 and held high continuously. Go to DONE on the first cycle with finish=1.
  - DONE: gray_ready=0, done=1. Go to READY on restart=1; this clears wr_count, the bitmap and both error flags. The image is retained.
- Read timing:
  - gray_data = gray_mem[gray_addr] as an asynchronous read, valid the same cycle gray_addr is stable.
  - The engine registers the address at edge k and samples data at edge k+1; zero-wait response is mandatory.
  - gray_data is 0 when gray_req=0.
- Write capture (READY only), on lbp_valid=1:
  - lbp_mem[lbp_addr] <= lbp_data; wr_count += 1; bitmap[lbp_addr] <= 1.
  - If bitmap[lbp_addr] was already 1, set dup_err. The write still overwrites.
- Same-cycle lbp_valid and finish in READY: the write is captured first, then the block enters DONE.
- proto_err is set on any of:
  - gray_req=1 or lbp_valid=1 in LOAD or DONE (the write is ignored);
  - finish=1 in LOAD;
  - load_valid=1 outside LOAD (the data is ignored).
- restart outside DONE is ignored and does not set an error.
- Readback: rd_data <= lbp_mem[rd_addr] every cycle; one-cycle latency, valid in any state.
- Widths:
  - wr_count saturates at 2**AW; it never wraps.
  - ld_cnt is AW+1 bits so the terminal count is detected exactly.

Decomposition:
- Package lbp_pkg holds:
  - state encoding: LOAD=0, READY=1, DONE=2;
  - image constants: W, H, AW, PIX_W=8.
- One sub-module is natural: lbp_dpram. It is a parameterized 2**AW×8 memory with:
  - one synchronous write port;
  - one asynchronous read port (gray path);
  - one registered read port (readback path).
- Instantiate lbp_dpram twice (gray_mem, lbp_mem). The FSM, counters and bitmap stay in the top.

Test Plan:
- Load pattern pix[a]=a[7:0] for 16384 cycles → gray_ready rises the cycle after the last load. gray_req=1, gray_addr=0x0081 → gray_data=0x81 in the same cycle.
- Reset pulse after 5000 loads, then a full load → gray_ready stays 0 until all 16384 new pixels are in; proto_err=0.
- Write lbp_addr=0x0000 data 0x00 and lbp_addr=0x0102 data 0xA5, then finish → done=1, wr_count=2. rd_addr=0x0102 → rd_data=0xA5 one cycle later.
- Write 0x0102 twice (0x11 then 0x22) → dup_err=1, wr_count=2, readback 0x22.
- lbp_valid together with finish, addr 0x3FFF data 0x7E → captured (wr_count increments, readback 0x7E), done=1. A later lbp_valid → proto_err=1, memory unchanged.
- Restart in DONE → gray_ready=1, wr_count=0, errors cleared. gray_addr=0x0081 still returns 0x81.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared state encoding and image geometry for the LBP host memory.
package lbp_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned IMG_H  = 128;
  localparam int unsigned IMG_AW = 14;
  localparam int unsigned PIX_W  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lbp_dpram.sv
// 2**AW x DW memory: one synchronous write port, one asynchronous read port,
// one registered read port whose output register is reset.
module lbp_dpram #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_araddr,
  output logic [DW-1:0] o_ardata,
  input  logic [AW-1:0] i_rraddr,
  output logic [DW-1:0] o_rrdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rrdata;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ardata = r_mem[i_araddr];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rrdata <= '0;
    end else begin
      r_rrdata <= r_mem[i_rraddr];
    end
  end

  assign o_rrdata = r_rrdata;

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side responder for the LBP engine: loads the gray image, serves reads,
// captures LBP writes with duplicate/protocol checking, and exposes results.
module lbp_host_mem
  import lbp_pkg::*;
#(
  parameter int unsigned W  = IMG_W,
  parameter int unsigned H  = IMG_H,
  parameter int unsigned AW = IMG_AW
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  input  logic [PIX_W-1:0] i_load_data,
  output logic             o_gray_ready,
  input  logic             i_gray_req,
  input  logic [AW-1:0]    i_gray_addr,
  output logic [PIX_W-1:0] o_gray_data,
  input  logic             i_lbp_valid,
  input  logic [AW-1:0]    i_lbp_addr,
  input  logic [PIX_W-1:0] i_lbp_data,
  input  logic             i_finish,
  input  logic             i_restart,
  output logic             o_done,
  output logic [AW:0]      o_wr_count,
  output logic             o_dup_err,
  output logic             o_proto_err,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [PIX_W-1:0] o_rd_data
);

  localparam int unsigned NPIX = W * H;
  localparam logic [AW:0] LAST_PIX = (AW+1)'(NPIX - 1);
  localparam logic [AW:0] WR_MAX   = (AW+1)'(NPIX);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW:0]       r_ld_cnt;
  logic [AW:0]       r_wr_count;
  logic              r_dup_err;
  logic              r_proto_err;
  logic [NPIX-1:0]   r_bitmap;

  logic              w_gray_we;
  logic              w_lbp_we;
  logic              w_restart;
  logic              w_proto_hit;
  logic [PIX_W-1:0]  w_gray_rdata;
  logic [PIX_W-1:0]  w_gray_rr_unused;
  logic [PIX_W-1:0]  w_lbp_ar_unused;
  logic              w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_gray_we   = 1'b0;
    w_lbp_we    = 1'b0;
    w_restart   = 1'b0;
    w_proto_hit = 1'b0;
    case (r_state)
      LOAD: begin
        w_gray_we   = i_load_valid;
        w_proto_hit = i_gray_req | i_lbp_valid | i_finish;
        if (i_load_valid && (r_ld_cnt == LAST_PIX)) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_lbp_we    = i_lbp_valid;
        w_proto_hit = i_load_valid;
        // A write in the same cycle as finish is still captured.
        if (i_finish) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_restart   = i_restart;
        w_proto_hit = i_gray_req | i_lbp_valid | i_load_valid;
        if (i_restart) begin
          w_state_nxt = READY;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ld_cnt <= '0;
    end else if (w_gray_we) begin
      r_ld_cnt <= r_ld_cnt + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_count  <= '0;
      r_dup_err   <= 1'b0;
      r_proto_err <= 1'b0;
      r_bitmap    <= '0;
    end else if (w_restart) begin
      r_wr_count  <= '0;
      r_dup_err   <= 1'b0;
      r_proto_err <= 1'b0;
      r_bitmap    <= '0;
    end else begin
      if (w_proto_hit) begin
        r_proto_err <= 1'b1;
      end
      if (w_lbp_we) begin
        r_bitmap[i_lbp_addr] <= 1'b1;
        if (r_bitmap[i_lbp_addr]) begin
          r_dup_err <= 1'b1;
        end
        if (r_wr_count != WR_MAX) begin
          r_wr_count <= r_wr_count + ONE;
        end
      end
    end
  end

  lbp_dpram #(
    .AW (AW),
    .DW (PIX_W)
  ) u_gray_mem (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we     (w_gray_we),
    .i_waddr  (r_ld_cnt[AW-1:0]),
    .i_wdata  (i_load_data),
    .i_araddr (i_gray_addr),
    .o_ardata (w_gray_rdata),
    .i_rraddr (i_rd_addr),
    .o_rrdata (w_gray_rr_unused)
  );

  lbp_dpram #(
    .AW (AW),
    .DW (PIX_W)
  ) u_lbp_mem (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we     (w_lbp_we),
    .i_waddr  (i_lbp_addr),
    .i_wdata  (i_lbp_data),
    .i_araddr (i_rd_addr),
    .o_ardata (w_lbp_ar_unused),
    .i_rraddr (i_rd_addr),
    .o_rrdata (o_rd_data)
  );

  assign w_unused = ^{w_gray_rr_unused, w_lbp_ar_unused};

  assign o_gray_data  = i_gray_req ? w_gray_rdata : '0;
  assign o_gray_ready = (r_state == READY);
  assign o_done       = (r_state == DONE);
  assign o_wr_count   = r_wr_count;
  assign o_dup_err    = r_dup_err;
  assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: load, reset abort, capture, duplicates,
// write-with-finish, protocol errors, restart and readback.
module tb_lbp_host_mem;

  localparam int AW = 14;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
  logic          restart;
  logic          done;
  logic [AW:0]   wr_count;
  logic          dup_err;
  logic          proto_err;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  lbp_host_mem dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_gray_ready (gray_ready),
    .i_gray_req   (gray_req),
    .i_gray_addr  (gray_addr),
    .o_gray_data  (gray_data),
    .i_lbp_valid  (lbp_valid),
    .i_lbp_addr   (lbp_addr),
    .i_lbp_data   (lbp_data),
    .i_finish     (finish),
    .i_restart    (restart),
    .o_done       (done),
    .o_wr_count   (wr_count),
    .o_dup_err    (dup_err),
    .o_proto_err  (proto_err),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives n pixels with value addr[7:0]; leaves load_valid high on the last one.
  task automatic load_pixels(input int n);
    for (int a = 0; a < n; a++) begin
      cyc();
      load_valid = 1'b1;
      load_data  = a[7:0];
    end
  endtask

  task automatic lbp_write(input logic [AW-1:0] a, input logic [7:0] d);
    cyc();
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
  endtask

  task automatic readback(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    cyc();
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic pulse_restart();
    cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    gray_req   = 1'b0;
    gray_addr  = '0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    restart    = 1'b0;
    rd_addr    = '0;

    #12;
    check("rst_gray_ready", {31'd0, gray_ready}, 32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_wr_count",   {17'd0, wr_count},   32'd0);
    check("rst_dup_err",    {31'd0, dup_err},    32'd0);
    check("rst_proto_err",  {31'd0, proto_err},  32'd0);
    check("rst_rd_data",    {24'd0, rd_data},    32'd0);
    cyc();
    reset = 1'b1;

    // Partial load, then abort with reset.
    load_pixels(5000);
    cyc();
    load_valid = 1'b0;
    reset      = 1'b0;
    #2;
    reset      = 1'b1;
    @(negedge clk);
    check("abort_gray_ready", {31'd0, gray_ready}, 32'd0);

    // Full load; ready only after the final pixel edge.
    load_pixels(16384);
    @(negedge clk);
    check("load_last_not_ready", {31'd0, gray_ready}, 32'd0);
    cyc();
    load_valid = 1'b0;
    @(negedge clk);
    check("load_ready",     {31'd0, gray_ready}, 32'd1);
    check("load_proto_err", {31'd0, proto_err},  32'd0);

    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1;
    check("gray_0081", {24'd0, gray_data}, 32'h81);
    gray_addr = 14'h3FFF;
    #1;
    check("gray_3fff", {24'd0, gray_data}, 32'hFF);
    gray_addr = 14'h1234;
    #1;
    check("gray_1234", {24'd0, gray_data}, 32'h34);
    gray_req = 1'b0;
    #1;
    check("gray_noreq", {24'd0, gray_data}, 32'h00);

    // Two distinct writes, then finish.
    lbp_write(14'h0000, 8'h00);
    lbp_write(14'h0102, 8'hA5);
    cyc();
    lbp_valid = 1'b0;
    finish    = 1'b1;
    cyc();
    finish = 1'b0;
    @(negedge clk);
    check("fin_done",       {31'd0, done},       32'd1);
    check("fin_gray_ready", {31'd0, gray_ready}, 32'd0);
    check("fin_wr_count",   {17'd0, wr_count},   32'd2);
    check("fin_dup_err",    {31'd0, dup_err},    32'd0);
    check("fin_proto_err",  {31'd0, proto_err},  32'd0);
    readback("rb_0102", 14'h0102, 8'hA5);
    readback("rb_0000", 14'h0000, 8'h00);

    // Restart, then duplicate write to one address.
    pulse_restart();
    check("rs1_ready",    {31'd0, gray_ready}, 32'd1);
    check("rs1_wr_count", {17'd0, wr_count},   32'd0);
    lbp_write(14'h0102, 8'h11);
    lbp_write(14'h0102, 8'h22);
    cyc();
    lbp_valid = 1'b0;
    @(negedge clk);
    check("dup_err",       {31'd0, dup_err},   32'd1);
    check("dup_wr_count",  {17'd0, wr_count},  32'd2);
    check("dup_proto_err", {31'd0, proto_err}, 32'd0);
    readback("rb_dup", 14'h0102, 8'h22);

    // Restart in READY has no effect.
    pulse_restart();
    check("rs_ready_ign",  {31'd0, gray_ready}, 32'd1);
    check("rs_ready_cnt",  {17'd0, wr_count},   32'd2);
    check("rs_ready_perr", {31'd0, proto_err},  32'd0);

    // Write together with finish is captured.
    lbp_write(14'h3FFF, 8'h7E);
    finish = 1'b1;
    cyc();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    @(negedge clk);
    check("wf_done",     {31'd0, done},     32'd1);
    check("wf_wr_count", {17'd0, wr_count}, 32'd3);
    readback("rb_3fff", 14'h3FFF, 8'h7E);

    // Write in DONE is ignored and flagged.
    lbp_write(14'h3FFF, 8'h55);
    cyc();
    lbp_valid = 1'b0;
    @(negedge clk);
    check("done_wr_perr", {31'd0, proto_err}, 32'd1);
    check("done_wr_cnt",  {17'd0, wr_count},  32'd3);
    readback("rb_3fff_kept", 14'h3FFF, 8'h7E);

    // Restart clears status; image retained.
    pulse_restart();
    check("rs2_ready",    {31'd0, gray_ready}, 32'd1);
    check("rs2_done",     {31'd0, done},       32'd0);
    check("rs2_wr_count", {17'd0, wr_count},   32'd0);
    check("rs2_dup_err",  {31'd0, dup_err},    32'd0);
    check("rs2_perr",     {31'd0, proto_err},  32'd0);
    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1;
    check("rs2_gray_0081", {24'd0, gray_data}, 32'h81);
    gray_req = 1'b0;

    // load_valid outside LOAD raises proto_err.
    cyc();
    load_valid = 1'b1;
    load_data  = 8'hEE;
    cyc();
    load_valid = 1'b0;
    @(negedge clk);
    check("ready_load_perr", {31'd0, proto_err}, 32'd1);
    gray_req  = 1'b1;
    gray_addr = 14'h0000;
    #1;
    check("ready_load_ign", {24'd0, gray_data}, 32'h00);
    gray_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
